// File: rtl/imem_loader.sv
// rtl/imem_loader.sv - byte-stream program loader for a 32-word instruction memory
// Assembles little-endian bytes into words and writes them while the CPU is stalled.
module imem_loader #(
    parameter int DEPTH  = 32,
    parameter int ADDR_W = 8,
    parameter int WORD_W = 32
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_load_start,
    input  logic [5:0]        i_load_len,
    input  logic              i_byte_valid,
    input  logic [7:0]        i_byte_data,
    output logic              o_byte_ready,
    input  logic [ADDR_W-1:0] i_cpu_pc,
    output logic [ADDR_W-1:0] o_imem_addr,
    output logic              o_mem_we,
    output logic [WORD_W-1:0] o_mem_wdata,
    output logic              o_cpu_stall,
    output logic              o_load_busy,
    output logic              o_load_done,
    output logic [5:0]        o_word_count
);

    localparam int         IDX_W   = $clog2(DEPTH);
    localparam logic [5:0] DEPTH_L = 6'(DEPTH);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RECV,
        S_WRITE,
        S_DONE
    } state_t;

    state_t             r_state;
    state_t             w_next;
    logic [5:0]         r_len;
    logic [5:0]         r_word_count;
    logic [1:0]         r_byte_idx;
    logic [IDX_W-1:0]   r_word_idx;
    logic [WORD_W-1:0]  r_asm;

    logic [5:0]         w_eff_len;
    logic [5:0]         w_count_inc;
    logic [ADDR_W-1:0]  w_loader_addr;
    logic               w_accept;

    // Out-of-range and zero lengths both mean a full-memory load.
    assign w_eff_len     = ((i_load_len == 6'd0) || (i_load_len > DEPTH_L)) ? DEPTH_L : i_load_len;
    assign w_count_inc   = r_word_count + 6'd1;
    assign w_loader_addr = ADDR_W'({r_word_idx, 2'b00});
    assign w_accept      = (r_state == S_RECV) && i_byte_valid;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next       = r_state;
        o_byte_ready = 1'b0;
        o_mem_we     = 1'b0;
        o_cpu_stall  = 1'b0;
        o_load_busy  = 1'b0;
        o_load_done  = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (i_load_start) begin
                    w_next = S_RECV;
                end
            end
            S_RECV: begin
                o_byte_ready = 1'b1;
                o_cpu_stall  = 1'b1;
                o_load_busy  = 1'b1;
                if (i_byte_valid && (r_byte_idx == 2'd3)) begin
                    w_next = S_WRITE;
                end
            end
            S_WRITE: begin
                o_mem_we    = 1'b1;
                o_cpu_stall = 1'b1;
                o_load_busy = 1'b1;
                w_next      = (w_count_inc == r_len) ? S_DONE : S_RECV;
            end
            S_DONE: begin
                o_load_done = 1'b1;
                o_cpu_stall = 1'b1;
                w_next      = S_IDLE;
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_len        <= 6'd0;
            r_word_count <= 6'd0;
            r_byte_idx   <= 2'd0;
            r_word_idx   <= '0;
            r_asm        <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (i_load_start) begin
                        r_len        <= w_eff_len;
                        r_word_count <= 6'd0;
                        r_byte_idx   <= 2'd0;
                        r_word_idx   <= '0;
                    end
                end
                S_RECV: begin
                    if (w_accept) begin
                        r_asm[{r_byte_idx, 3'b000} +: 8] <= i_byte_data;
                        r_byte_idx                       <= r_byte_idx + 2'd1;
                    end
                end
                S_WRITE: begin
                    r_word_count <= w_count_inc;
                    r_word_idx   <= r_word_idx + 1'b1;
                    r_byte_idx   <= 2'd0;
                end
                default: begin
                end
            endcase
        end
    end

    // Fetch only sees the memory when no load is in flight.
    assign o_imem_addr  = (r_state == S_IDLE) ? i_cpu_pc : w_loader_addr;
    assign o_mem_wdata  = r_asm;
    assign o_word_count = r_word_count;

endmodule

// File: tb/tb_imem_loader.sv
// tb/tb_imem_loader.sv - scoreboard bench for imem_loader
// Expected writes and completions are queued by stimulus and consumed by a monitor.
module tb_imem_loader;

    logic        clk;
    logic        rst_n;
    logic        load_start;
    logic [5:0]  load_len;
    logic        byte_valid;
    logic [7:0]  byte_data;
    logic        byte_ready;
    logic [7:0]  cpu_pc;
    logic [7:0]  imem_addr;
    logic        mem_we;
    logic [31:0] mem_wdata;
    logic        cpu_stall;
    logic        load_busy;
    logic        load_done;
    logic [5:0]  word_count;

    int checks = 0;
    int errors = 0;

    logic [39:0] wr_q[$];
    int          done_q[$];
    logic        prev_done = 1'b0;

    imem_loader dut (
        .i_clk        (clk),
        .i_rst_n      (rst_n),
        .i_load_start (load_start),
        .i_load_len   (load_len),
        .i_byte_valid (byte_valid),
        .i_byte_data  (byte_data),
        .o_byte_ready (byte_ready),
        .i_cpu_pc     (cpu_pc),
        .o_imem_addr  (imem_addr),
        .o_mem_we     (mem_we),
        .o_mem_wdata  (mem_wdata),
        .o_cpu_stall  (cpu_stall),
        .o_load_busy  (load_busy),
        .o_load_done  (load_done),
        .o_word_count (word_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            if (prev_done) begin
                check("stall_after_done", {63'd0, cpu_stall}, 64'd0);
            end
            if (mem_we) begin
                if (wr_q.size() == 0) begin
                    check("unexpected_write", {56'd0, imem_addr}, 64'hFFFF);
                end else begin
                    logic [39:0] e;
                    e = wr_q.pop_front();
                    check("write_addr", {56'd0, imem_addr}, {56'd0, e[39:32]});
                    check("write_data", {32'd0, mem_wdata}, {32'd0, e[31:0]});
                end
            end
            if (load_done) begin
                check("stall_in_done", {63'd0, cpu_stall}, 64'd1);
                if (done_q.size() == 0) begin
                    check("unexpected_done", {58'd0, word_count}, 64'hFFFF);
                end else begin
                    int n;
                    n = done_q.pop_front();
                    check("done_word_count", {58'd0, word_count}, 64'(n));
                end
            end
            prev_done = load_done;
        end else begin
            prev_done = 1'b0;
        end
    end

    task automatic push_word(input logic [7:0] addr, input logic [31:0] data);
        wr_q.push_back({addr, data});
    endtask

    task automatic start_load(input logic [5:0] len);
        load_len   = len;
        load_start = 1'b1;
        @(posedge clk);
        #1;
        load_start = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b);
        bit ok;
        ok         = 1'b0;
        byte_valid = 1'b1;
        byte_data  = b;
        for (int i = 0; i < 50 && !ok; i++) begin
            @(negedge clk);
            if (byte_ready) ok = 1'b1;
            @(posedge clk);
            #1;
        end
        byte_valid = 1'b0;
        if (!ok) check("byte_timeout", 64'd0, 64'd1);
    endtask

    task automatic gap(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            check("ready_in_gap", {63'd0, byte_ready}, 64'd1);
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wait_idle();
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 3000 && !ok; i++) begin
            @(negedge clk);
            if (!load_busy && !cpu_stall) ok = 1'b1;
        end
        @(posedge clk);
        #1;
        if (!ok) check("idle_timeout", 64'd0, 64'd1);
    endtask

    task automatic send_word(input logic [31:0] w);
        for (int k = 0; k < 4; k++) send_byte(w[8*k +: 8]);
    endtask

    initial begin
        rst_n      = 1'b0;
        load_start = 1'b0;
        load_len   = 6'd0;
        byte_valid = 1'b0;
        byte_data  = 8'h00;
        cpu_pc     = 8'h40;
        repeat (3) @(posedge clk);
        #1;
        check("rst_ready", {63'd0, byte_ready}, 64'd0);
        check("rst_we", {63'd0, mem_we}, 64'd0);
        check("rst_stall", {63'd0, cpu_stall}, 64'd0);
        check("rst_busy", {63'd0, load_busy}, 64'd0);
        check("rst_done", {63'd0, load_done}, 64'd0);
        check("rst_count", {58'd0, word_count}, 64'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Two words back-to-back
        push_word(8'h00, 32'h10203317);
        push_word(8'h04, 32'hABCDE397);
        done_q.push_back(2);
        start_load(6'd2);
        check("stall_in_recv", {63'd0, cpu_stall}, 64'd1);
        send_word(32'h10203317);
        send_word(32'hABCDE397);
        wait_idle();
        check("count_hold_2", {58'd0, word_count}, 64'd2);

        // Same stream with a valid gap between bytes 1 and 2
        push_word(8'h00, 32'h10203317);
        push_word(8'h04, 32'hABCDE397);
        done_q.push_back(2);
        start_load(6'd2);
        send_byte(8'h17);
        send_byte(8'h33);
        gap(3);
        send_byte(8'h20);
        send_byte(8'h10);
        send_word(32'hABCDE397);
        wait_idle();

        // Full-depth load via load_len=0
        for (int w = 0; w < 32; w++) begin
            logic [7:0] b0;
            b0 = 8'(4 * w);
            push_word(8'(4 * w), {b0 + 8'd3, b0 + 8'd2, b0 + 8'd1, b0});
        end
        done_q.push_back(32);
        start_load(6'd0);
        for (int i = 0; i < 128; i++) send_byte(8'(i));
        wait_idle();
        check("count_full", {58'd0, word_count}, 64'd32);

        // load_start during RECV is ignored
        push_word(8'h00, 32'h00C0FFEE);
        done_q.push_back(1);
        start_load(6'd1);
        send_byte(8'hEE);
        load_len   = 6'd3;
        load_start = 1'b1;
        @(posedge clk);
        #1;
        load_start = 1'b0;
        send_byte(8'hFF);
        send_byte(8'hC0);
        send_byte(8'h00);
        wait_idle();
        repeat (5) begin
            @(negedge clk);
            check("no_queued_load", {63'd0, load_busy}, 64'd0);
        end
        @(posedge clk);
        #1;
        check("count_single", {58'd0, word_count}, 64'd1);

        // Reset in the middle of word 1
        push_word(8'h00, 32'h44332211);
        start_load(6'd2);
        send_word(32'h44332211);
        send_byte(8'h55);
        send_byte(8'h66);
        rst_n = 1'b0;
        #1;
        check("midrst_stall", {63'd0, cpu_stall}, 64'd0);
        check("midrst_count", {58'd0, word_count}, 64'd0);
        check("midrst_busy", {63'd0, load_busy}, 64'd0);
        check("midrst_addr", {56'd0, imem_addr}, {56'd0, cpu_pc});
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        push_word(8'h00, 32'hDEADBEEF);
        done_q.push_back(1);
        start_load(6'd1);
        send_word(32'hDEADBEEF);
        wait_idle();

        // IDLE address pass-through
        for (int p = 0; p <= 8'h14; p++) begin
            cpu_pc = 8'(p);
            #1;
            check("idle_addr", {56'd0, imem_addr}, 64'(p));
            check("idle_we", {63'd0, mem_we}, 64'd0);
            check("idle_ready", {63'd0, byte_ready}, 64'd0);
            @(posedge clk);
            #1;
        end

        check("writes_left", 64'(wr_q.size()), 64'd0);
        check("dones_left", 64'(done_q.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog actual=running expected=finished");
        $fatal(1);
    end

endmodule
